// File: rtl/id_stage.sv
// Decode/operand stage: one-cycle registered operand bundle with load-use stall, optional
// EX/MEM/WB forwarding when ID_FORWARD_EN is defined (otherwise any pending writer stalls).
module id_stage #(
   parameter int BitWidth = 32,
   parameter int RegCount = 32,
   localparam int AW = $clog2(RegCount)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [31:0]         in_pc,
   output logic [AW-1:0]       rf_raddr1,
   output logic [AW-1:0]       rf_raddr2,
   input  logic [BitWidth-1:0] rf_rdata1,
   input  logic [BitWidth-1:0] rf_rdata2,
   input  logic                ex_wr_en,
   input  logic [AW-1:0]       ex_wr_addr,
   input  logic                ex_is_load,
   input  logic [BitWidth-1:0] ex_result,
   input  logic                mem_wr_en,
   input  logic [AW-1:0]       mem_wr_addr,
   input  logic [BitWidth-1:0] mem_result,
   input  logic                wb_wr_en,
   input  logic [AW-1:0]       wb_wr_addr,
   input  logic [BitWidth-1:0] wb_data,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BitWidth-1:0] out_rs_val,
   output logic [BitWidth-1:0] out_rt_val,
   output logic [BitWidth-1:0] out_imm,
   output logic [BitWidth-1:0] out_pc,
   output logic [AW-1:0]       out_dst,
   output logic [5:0]          out_opcode,
   output logic [5:0]          out_funct,
   output logic [15:0]         stall_count
);

   logic [5:0]          opcode;
   logic [AW-1:0]       rsAddr, rtAddr, rdAddr, dstAddr;
   logic [BitWidth-1:0] rsVal, rtVal, immVal;
   logic                stall, transfer;

   assign opcode    = in_instr[31:26];
   assign rsAddr    = AW'(in_instr[25:21]);
   assign rtAddr    = AW'(in_instr[20:16]);
   assign rdAddr    = AW'(in_instr[15:11]);
   assign rf_raddr1 = rsAddr;
   assign rf_raddr2 = rtAddr;

   function automatic logic hits(input logic en, input logic [AW-1:0] wa, input logic [AW-1:0] ra);
      return en && (wa == ra) && (ra != '0);
   endfunction

   // Later assignments override earlier ones, so the youngest writer wins.
   function automatic logic [BitWidth-1:0] operand(input logic [AW-1:0] ra, input logic [BitWidth-1:0] rfVal);
      logic [BitWidth-1:0] v;
      v = '0;
      if (ra != '0) v = rfVal;
`ifdef ID_FORWARD_EN
      if (hits(wb_wr_en, wb_wr_addr, ra))   v = wb_data;
      if (hits(mem_wr_en, mem_wr_addr, ra)) v = mem_result;
      if (hits(ex_wr_en, ex_wr_addr, ra))   v = ex_result;
`endif
      return v;
   endfunction

`ifdef ID_FORWARD_EN
   assign stall = ex_wr_en && ex_is_load &&
                  (hits(1'b1, ex_wr_addr, rsAddr) || hits(1'b1, ex_wr_addr, rtAddr));
`else
   assign stall = hits(ex_wr_en, ex_wr_addr, rsAddr)   || hits(ex_wr_en, ex_wr_addr, rtAddr)   ||
                  hits(mem_wr_en, mem_wr_addr, rsAddr) || hits(mem_wr_en, mem_wr_addr, rtAddr) ||
                  hits(wb_wr_en, wb_wr_addr, rsAddr)   || hits(wb_wr_en, wb_wr_addr, rtAddr);
   logic unusedFwd;
   assign unusedFwd = ^{ex_is_load, ex_result, mem_result, wb_data};
`endif

   always_comb begin
      rsVal   = operand(rsAddr, rf_rdata1);
      rtVal   = operand(rtAddr, rf_rdata2);
      dstAddr = rtAddr;
      if (opcode == 6'h00)      dstAddr = rdAddr;
      else if (opcode == 6'h03) dstAddr = AW'(5'd31);
      immVal = {{(BitWidth-16){in_instr[15]}}, in_instr[15:0]};
      if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
         immVal = {{(BitWidth-16){1'b0}}, in_instr[15:0]};
   end

   assign in_ready = (!out_valid || out_ready) && !stall && !flush;
   assign transfer = in_valid && in_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_rs_val <= '0;
         out_rt_val <= '0;
         out_imm    <= '0;
         out_pc     <= '0;
         out_dst    <= '0;
         out_opcode <= '0;
         out_funct  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (transfer) begin
         out_valid  <= 1'b1;
         out_rs_val <= rsVal;
         out_rt_val <= rtVal;
         out_imm    <= immVal;
         out_pc     <= BitWidth'(in_pc);
         out_dst    <= dstAddr;
         out_opcode <= opcode;
         out_funct  <= in_instr[5:0];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         stall_count <= '0;
      else if (in_valid && stall && !flush && stall_count != 16'hFFFF)
         stall_count <= stall_count + 16'd1;
   end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus a randomized run against a spec-level model.
module tb_id_stage;

   logic        clock, reset;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
   logic [4:0]  ex_wr_addr, mem_wr_addr, wb_wr_addr;
   logic [31:0] ex_result, mem_result, wb_data;
   logic        flush, out_valid, out_ready;
   logic [31:0] out_rs_val, out_rt_val, out_imm, out_pc;
   logic [4:0]  out_dst;
   logic [5:0]  out_opcode, out_funct;
   logic [15:0] stall_count;

   int errors = 0;
   int checks = 0;

   id_stage dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load), .ex_result(ex_result),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_result(mem_result),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm), .out_pc(out_pc),
      .out_dst(out_dst), .out_opcode(out_opcode), .out_funct(out_funct),
      .stall_count(stall_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic idle();
      in_valid = 0; in_instr = 0; in_pc = 0; rf_rdata1 = 0; rf_rdata2 = 0;
      ex_wr_en = 0; ex_wr_addr = 0; ex_is_load = 0; ex_result = 0;
      mem_wr_en = 0; mem_wr_addr = 0; mem_result = 0;
      wb_wr_en = 0; wb_wr_addr = 0; wb_data = 0;
      flush = 0; out_ready = 1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1; #1; reset = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
      checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", stall_count); end
      checks++; if (out_rs_val !== 32'd0 || out_imm !== 32'd0 || out_dst !== 5'd0)
         begin errors++; $display("FAIL reset_payload rs=%h imm=%h dst=%0d want 0", out_rs_val, out_imm, out_dst); end
      reset = 0;
      tick();
   endtask

   task automatic test_basic();
      idle();
      in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h21); in_pc = 32'h100;
      rf_rdata1 = 5; rf_rdata2 = 7; in_valid = 1;
      @(negedge clock);
      checks++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2)
         begin errors++; $display("FAIL basic_raddr got=%0d,%0d want=1,2", rf_raddr1, rf_raddr2); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%0b want=1", in_ready); end
      tick();
      in_valid = 0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
      checks++; if (out_rs_val !== 32'd5 || out_rt_val !== 32'd7)
         begin errors++; $display("FAIL basic_ops got=%0d,%0d want=5,7", out_rs_val, out_rt_val); end
      checks++; if (out_dst !== 5'd3 || out_funct !== 6'h21 || out_opcode !== 6'h00 || out_pc !== 32'h100)
         begin errors++; $display("FAIL basic_fields dst=%0d fn=%h op=%h pc=%h want 3,21,0,100",
                                  out_dst, out_funct, out_opcode, out_pc); end
      tick();
   endtask

   task automatic test_forward();
      idle();
      in_instr = rtype(5'd1, 5'd9, 5'd4, 6'h21); rf_rdata1 = 32'h11; in_valid = 1;
      ex_wr_en = 1; ex_wr_addr = 1; ex_result = 32'hAA;
      mem_wr_en = 1; mem_wr_addr = 1; mem_result = 32'hBB;
      wb_wr_addr = 1; wb_data = 32'hCC;
`ifdef ID_FORWARD_EN
      tick();
      checks++; if (out_valid !== 1'b1 || out_rs_val !== 32'hAA)
         begin errors++; $display("FAIL fwd_ex valid=%0b rs=%h want 1,aa", out_valid, out_rs_val); end
      ex_wr_en = 0; wb_wr_en = 1;
      tick();
      checks++; if (out_rs_val !== 32'hBB) begin errors++; $display("FAIL fwd_mem rs=%h want bb", out_rs_val); end
      mem_wr_en = 0;
      tick();
      checks++; if (out_rs_val !== 32'hCC) begin errors++; $display("FAIL fwd_wb rs=%h want cc", out_rs_val); end
`else
      @(negedge clock);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nofwd_stall ready=%0b want 0", in_ready); end
      tick();
      ex_wr_en = 0; mem_wr_en = 0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_rs_val !== 32'h11)
         begin errors++; $display("FAIL nofwd_rf valid=%0b rs=%h want 1,11", out_valid, out_rs_val); end
`endif
      idle();
      tick();
   endtask

   task automatic test_zero_reg();
      idle();
      in_instr = itype(6'h0D, 5'd0, 5'd5, 16'hFFFF); rf_rdata1 = 32'h1234; in_valid = 1;
      ex_wr_en = 1; ex_wr_addr = 0; ex_result = 32'hFF;
      tick();
      idle();
      checks++; if (out_valid !== 1'b1 || out_rs_val !== 32'd0)
         begin errors++; $display("FAIL zero_reg valid=%0b rs=%h want 1,0", out_valid, out_rs_val); end
      checks++; if (out_imm !== 32'h0000FFFF || out_dst !== 5'd5)
         begin errors++; $display("FAIL zero_ori imm=%h dst=%0d want 0000ffff,5", out_imm, out_dst); end
      tick();
   endtask

   task automatic test_decode();
      logic [31:0] tInstr [4];
      logic [4:0]  tDst [4];
      logic [31:0] tImm [4];
      tInstr[0] = 32'h0C000010;                        tDst[0] = 31; tImm[0] = 32'h00000010;
      tInstr[1] = itype(6'h08, 5'd1, 5'd4, 16'hFFFE);  tDst[1] = 4;  tImm[1] = 32'hFFFFFFFE;
      tInstr[2] = itype(6'h0E, 5'd1, 5'd6, 16'h8000);  tDst[2] = 6;  tImm[2] = 32'h00008000;
      tInstr[3] = itype(6'h23, 5'd1, 5'd7, 16'h8000);  tDst[3] = 7;  tImm[3] = 32'hFFFF8000;
      for (int i = 0; i < 4; i++) begin
         idle();
         in_instr = tInstr[i]; in_valid = 1;
         tick();
         checks++; if (out_valid !== 1'b1 || out_dst !== tDst[i] || out_imm !== tImm[i])
            begin errors++; $display("FAIL decode_%0d valid=%0b dst=%0d imm=%h want 1,%0d,%h",
                                     i, out_valid, out_dst, out_imm, tDst[i], tImm[i]); end
      end
      idle();
      tick();
   endtask

   task automatic test_load_use();
      idle();
      pulse_reset();
      in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h21); rf_rdata1 = 5; rf_rdata2 = 9; in_valid = 1;
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 2; ex_result = 32'h77;
      @(negedge clock);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready ready=%0b want 0", in_ready); end
      tick();
      checks++; if (stall_count !== 16'd1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL lu_count cnt=%0d valid=%0b want 1,0", stall_count, out_valid); end
      ex_is_load = 0;
`ifndef ID_FORWARD_EN
      ex_wr_en = 0;
`endif
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release ready=%0b want 1", in_ready); end
      tick();
`ifdef ID_FORWARD_EN
      checks++; if (out_valid !== 1'b1 || out_rt_val !== 32'h77 || stall_count !== 16'd1)
         begin errors++; $display("FAIL lu_capture valid=%0b rt=%h cnt=%0d want 1,77,1", out_valid, out_rt_val, stall_count); end
`else
      checks++; if (out_valid !== 1'b1 || out_rt_val !== 32'd9 || stall_count !== 16'd1)
         begin errors++; $display("FAIL lu_capture valid=%0b rt=%h cnt=%0d want 1,9,1", out_valid, out_rt_val, stall_count); end
`endif
      idle();
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] heldRs, heldImm;
      idle();
      in_instr = itype(6'h08, 5'd1, 5'd4, 16'hFFFE); rf_rdata1 = 32'h3; in_valid = 1;
      tick();
      heldRs = 32'h3; heldImm = 32'hFFFFFFFE;
      out_ready = 0;
      in_instr = rtype(5'd2, 5'd3, 5'd8, 6'h25); rf_rdata1 = 32'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d ready=%0b want 0", i, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b1 || out_rs_val !== heldRs || out_imm !== heldImm)
            begin errors++; $display("FAIL bp_hold_%0d valid=%0b rs=%h imm=%h want 1,%h,%h",
                                     i, out_valid, out_rs_val, out_imm, heldRs, heldImm); end
      end
      flush = 1; out_ready = 1;
      @(negedge clock);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready ready=%0b want 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid valid=%0b want 0", out_valid); end
      idle();
      tick();
   endtask

   task automatic test_saturate();
      idle();
      pulse_reset();
      in_instr = rtype(5'd1, 5'd3, 5'd4, 6'h21); rf_rdata1 = 32'h9; in_valid = 1; out_ready = 0;
      tick();
      in_instr = rtype(5'd2, 5'd3, 5'd5, 6'h21);
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 2;
      repeat (70000) @(posedge clock);
      #1;
      checks++; if (stall_count !== 16'hFFFF || out_valid !== 1'b1)
         begin errors++; $display("FAIL sat_count cnt=%h valid=%0b want ffff,1", stall_count, out_valid); end
      @(negedge clock);
      #1 reset = 1;
      #1;
      checks++; if (out_valid !== 1'b0 || stall_count !== 16'd0 || out_rs_val !== 32'd0)
         begin errors++; $display("FAIL async_reset valid=%0b cnt=%0d rs=%h want 0,0,0", out_valid, stall_count, out_rs_val); end
      #1 reset = 0;
      ex_wr_en = 0; ex_is_load = 0; out_ready = 1; rf_rdata1 = 32'h42;
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready ready=%0b want 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_rs_val !== 32'h42)
         begin errors++; $display("FAIL post_reset_xfer valid=%0b rs=%h want 1,42", out_valid, out_rs_val); end
      idle();
      tick();
   endtask

   // Reference model: expected operand, destination and immediate derived directly from the ISA rules.
   function automatic logic [31:0] refOperand(input logic [4:0] a, input logic [31:0] rfVal);
      if (a == 0) return 32'd0;
`ifdef ID_FORWARD_EN
      if (ex_wr_en && ex_wr_addr == a)   return ex_result;
      if (mem_wr_en && mem_wr_addr == a) return mem_result;
      if (wb_wr_en && wb_wr_addr == a)   return wb_data;
`endif
      return rfVal;
   endfunction

   function automatic bit refHazard(input logic [4:0] rs, input logic [4:0] rt);
      logic [4:0] wa [3];
      bit         we [3];
      bit         h;
      wa[0] = ex_wr_addr; wa[1] = mem_wr_addr; wa[2] = wb_wr_addr;
`ifdef ID_FORWARD_EN
      we[0] = ex_wr_en && ex_is_load; we[1] = 0; we[2] = 0;
`else
      we[0] = ex_wr_en; we[1] = mem_wr_en; we[2] = wb_wr_en;
`endif
      h = 0;
      for (int k = 0; k < 3; k++)
         if (we[k] && wa[k] != 0 && (wa[k] == rs || wa[k] == rt)) h = 1;
      return h;
   endfunction

   task automatic test_random();
      logic [5:0]  ops [7];
      logic [5:0]  op;
      logic [4:0]  rs, rt;
      logic [15:0] imm;
      logic signed [15:0] simm;
      bit          mValid, expReady, hz;
      logic [31:0] mRs, mRt, mImm, mPc;
      logic [4:0]  mDst;
      logic [5:0]  mOp, mFn;
      int          mStall;
      ops[0] = 6'h00; ops[1] = 6'h03; ops[2] = 6'h08; ops[3] = 6'h0C;
      ops[4] = 6'h0D; ops[5] = 6'h0E; ops[6] = 6'h23;
      idle();
      pulse_reset();
      mValid = 0; mRs = 0; mRt = 0; mImm = 0; mPc = 0; mDst = 0; mOp = 0; mFn = 0; mStall = 0;
      for (int c = 0; c < 2000; c++) begin
         op  = ops[$urandom_range(0, 6)];
         rs  = 5'($urandom_range(0, 3));
         rt  = 5'($urandom_range(0, 3));
         imm = 16'($urandom);
         in_instr  = {op, rs, rt, imm};
         in_pc     = $urandom;
         in_valid  = ($urandom_range(0, 4) != 0);
         rf_rdata1 = $urandom; rf_rdata2 = $urandom;
         ex_wr_en  = $urandom_range(0, 1); ex_wr_addr  = 5'($urandom_range(0, 3));
         ex_is_load = ($urandom_range(0, 2) == 0); ex_result = $urandom;
         mem_wr_en = $urandom_range(0, 1); mem_wr_addr = 5'($urandom_range(0, 3)); mem_result = $urandom;
         wb_wr_en  = $urandom_range(0, 1); wb_wr_addr  = 5'($urandom_range(0, 3)); wb_data = $urandom;
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clock);
         hz = refHazard(rs, rt);
         expReady = (!mValid || out_ready) && !hz && !flush;
         checks++; if (in_ready !== expReady)
            begin errors++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", c, in_ready, expReady); end
         checks++; if (out_valid !== mValid || stall_count !== 16'(mStall))
            begin errors++; $display("FAIL rnd_state cyc=%0d valid=%0b cnt=%0d want %0b,%0d",
                                     c, out_valid, stall_count, mValid, mStall); end
         if (mValid) begin
            checks++; if (out_rs_val !== mRs || out_rt_val !== mRt || out_imm !== mImm || out_pc !== mPc ||
                          out_dst !== mDst || out_opcode !== mOp || out_funct !== mFn)
               begin errors++; $display("FAIL rnd_payload cyc=%0d rs=%h rt=%h imm=%h dst=%0d want %h,%h,%h,%0d",
                                        c, out_rs_val, out_rt_val, out_imm, out_dst, mRs, mRt, mImm, mDst); end
         end
         if (in_valid && hz && !flush && mStall < 65535) mStall++;
         if (flush) mValid = 0;
         else if (in_valid && expReady) begin
            mValid = 1;
            mRs = refOperand(rs, rf_rdata1);
            mRt = refOperand(rt, rf_rdata2);
            simm = imm;
            mImm = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'h0, imm} : 32'(simm);
            mDst = (op == 6'h00) ? in_instr[15:11] : (op == 6'h03) ? 5'd31 : rt;
            mPc = in_pc; mOp = op; mFn = in_instr[5:0];
         end else if (out_ready) mValid = 0;
         tick();
      end
      idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_forward();
      test_zero_reg();
      test_decode();
      test_load_use();
      test_backpressure();
      test_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter BitWidth, default 32, datapath width.
REQ-002 SHALL have parameter RegCount, default 32, architectural registers; AW = ceil(log2(RegCount)), 5 at default.
REQ-003 clock  in  1  all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 in_valid in 1 / in_ready out 1 / in_instr in 32 / in_pc in 32: fetch-side handshake and payload.
REQ-006 rf_raddr1 out AW, rf_raddr2 out AW: register-file read addresses; rf_rdata1 in BitWidth, rf_rdata2 in BitWidth: combinational read data.
REQ-007 ex_wr_en in 1, ex_wr_addr in AW, ex_is_load in 1, ex_result in BitWidth: writer currently in EX.
REQ-008 mem_wr_en in 1, mem_wr_addr in AW, mem_result in BitWidth; wb_wr_en in 1, wb_wr_addr in AW, wb_data in BitWidth: writers in MEM and WB.
REQ-009 flush in 1: discard held and incoming instruction.
REQ-010 out_valid out 1 / out_ready in 1: EX-side handshake.
REQ-011 out_rs_val, out_rt_val, out_imm, out_pc (BitWidth each), out_dst out AW, out_opcode out 6, out_funct out 6: registered operand bundle.
REQ-012 stall_count out 16: saturating hazard-stall counter.

Function
REQ-013 rf_raddr1 SHALL be in_instr[25:21] (rs) and rf_raddr2 in_instr[20:16] (rt), combinationally.
REQ-014 Single-entry output register; a transfer SHALL occur when in_valid && in_ready.
REQ-015 in_ready SHALL be (!out_valid || out_ready) && !stall && !flush.
REQ-016 Load-use stall SHALL assert when ex_wr_en && ex_is_load && ex_wr_addr != 0 && ex_wr_addr matches rs or rt.
REQ-017 Operand source priority per operand SHALL be EX > MEM > WB > register file; a source matches only if its wr_en = 1 and its addr equals the operand address and is nonzero.
REQ-018 Operand address 0 SHALL yield 0 regardless of any forwarding source or rf_rdata.
REQ-019 out_dst SHALL be rd (instr[15:11]) for opcode 0, 31 for opcode 0x03 (jal), else rt.
REQ-020 out_imm SHALL be instr[15:0] sign-extended to BitWidth, except zero-extended for opcodes 0x0C, 0x0D, 0x0E (andi, ori, xori).
REQ-021 On transfer, all out_* SHALL load next cycle with out_valid = 1; latency is one cycle.
REQ-022 Without transfer, out_valid SHALL clear when out_ready = 1 and hold otherwise; payload SHALL hold while out_valid && !out_ready.
REQ-023 flush SHALL take priority over everything: out_valid = 0 next cycle, no transfer that cycle.
REQ-024 stall_count SHALL increment by 1 in each cycle with in_valid && stall && !flush, and saturate at 0xFFFF.

Reset
REQ-025 reset SHALL force out_valid = 0, all out_* payload = 0, and stall_count = 0 immediately, independent of clock.
REQ-026 Reset mid-stall SHALL drop the stalled bundle; the first transfer after deassertion SHALL occur at the first clock edge where in_valid && in_ready.

Configuration
REQ-027 With macro ID_FORWARD_EN defined, forwarding SHALL follow REQ-017 and stalling SHALL be limited to REQ-016.
REQ-028 Without ID_FORWARD_EN, operands SHALL come only from the register file (still subject to REQ-018), and stall SHALL assert whenever any EX, MEM, or WB writer matches rs or rt (nonzero).

Verification
REQ-029 After reset, send addu $3,$1,$2 with rf_rdata1=5 and rf_rdata2=7, no writers active -> next cycle out_valid=1, rs_val=5, rt_val=7, dst=3.
REQ-030 With ID_FORWARD_EN: ex_wr 1<-0xAA, mem_wr 1<-0xBB, rf=0x11 -> rs_val=0xAA; with only mem and wb active, rs_val=mem_result.
REQ-031 Load in EX writes $2 and the incoming instr reads $2 -> in_ready=0 for 1 cycle and stall_count=1; when ex_is_load drops, the bundle captures.
REQ-032 Reading $0 with ex_wr_en=1, ex_wr_addr=0, ex_result=0xFF -> rs_val=0.
REQ-033 out_ready=0 for 3 cycles -> payload stable, in_ready=0; then assert flush -> out_valid=0 next cycle.
REQ-034 Hold stall 70000 cycles -> stall_count=0xFFFF; assert reset mid-stall -> out_valid=0 and stall_count=0 immediately.
